// File: rtl/mul_arb.sv
// rtl/mul_arb.sv - two-requester round-robin front end for a shared multiplier; optional abort via `MUL_ARB_TIMEOUT_EN
module mul_arb #(
    parameter int TIMEOUT = 64
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        req0,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic        req1,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [16:0] res,
    output logic        err,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic        mul_start,
    input  logic [16:0] mul_o,
    input  logic        mul_fin
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        win_q, win_d;
    logic        last_q, last_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        mul_start_q, mul_start_d;
    logic [16:0] res_q, res_d;
    logic [7:0]  mul_a_q, mul_a_d;
    logic [7:0]  mul_b_q, mul_b_d;

    logic        grant;
    logic        fin_ok;
    logic        timeout_hit;

    // Round-robin pick: on contention the requester not served last wins
    assign grant  = (req0 && req1) ? ~last_q : req1;

    // A completion flag seen while start is still asserted belongs to an older operation
    assign fin_ok = mul_fin && !mul_start_q;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign timeout_hit = (state_q == BUSY) && (cnt_q == CNT_LAST);
    assign err         = err_q;

    // Count cycles spent in BUSY; cleared everywhere else so each operation starts fresh
    always_comb begin
        cnt_d = '0;
        if (state_q == BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Busy-cycle counter register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // State register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (fin_ok || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values; every output is a flop so pulses land one cycle after the deciding edge
    always_comb begin
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mul_start_d = 1'b0;
        res_d       = res_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        win_d       = win_q;
        last_d      = last_q;
`ifdef MUL_ARB_TIMEOUT_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d       = grant;
                    mul_a_d     = grant ? a1 : a0;
                    mul_b_d     = grant ? b1 : b0;
                    ack0_d      = ~grant;
                    ack1_d      = grant;
                    mul_start_d = 1'b1;
                end
            end
            BUSY: begin
                if (fin_ok) begin
                    res_d   = mul_o;
                    done0_d = ~win_q;
                    done1_d = win_q;
`ifdef MUL_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end else if (timeout_hit) begin
                    res_d   = '0;
                    done0_d = ~win_q;
                    done1_d = win_q;
`ifdef MUL_ARB_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            DONE: begin
                // Pointer moves only once the operation has fully retired
                last_d = win_q;
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers; pointer resets to requester 1 so requester 0 wins first
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mul_start_q <= 1'b0;
            res_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            win_q       <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            mul_start_q <= mul_start_d;
            res_q       <= res_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            win_q       <= win_d;
            last_q      <= last_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign mul_start = mul_start_q;
    assign res       = res_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul_arb.sv
// tb/tb_mul_arb.sv - self-checking bench for mul_arb (timeout case built when MUL_ARB_TIMEOUT_EN is defined)
module tb_mul_arb;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        ack0, ack1, done0, done1, err, mul_start;
    logic [16:0] res;
    logic [7:0]  mul_a, mul_b;
    logic [16:0] mul_o;
    logic        mul_fin;

    int n_tests = 0;
    int n_fail  = 0;

    mul_arb #(.TIMEOUT(16)) dut (
        .ck(ck), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .res(res), .err(err),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_o(mul_o), .mul_fin(mul_fin)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic        id;
        logic [16:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        r0;
        logic [7:0]  a0, b0;
        logic        r1;
        logic [7:0]  a1, b1;
        int          lat;
        logic        first;
        logic [16:0] e0, e1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic void push(input logic id, input logic [16:0] r, input logic e);
        exp_t x;
        x.id  = id;
        x.res = r;
        x.err = e;
        sb.push_back(x);
    endfunction

    // Multiplier model: result after lat_v cycles (0 = never); force_fin models a stale flag
    int          lat_v = 1;
    int          pend = 0;
    bit          force_fin = 0;
    bit          stale_drop = 0;
    bit          fire;
    logic [7:0]  ma, mb;

    initial begin
        mul_fin = 1'b0;
        mul_o   = '0;
        ma      = '0;
        mb      = '0;
        forever begin
            @(negedge ck);
            if (stale_drop) force_fin = 0;
            stale_drop = mul_start && force_fin;
            fire = 0;
            if (mul_start) begin
                ma   = mul_a;
                mb   = mul_b;
                pend = lat_v;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) fire = 1;
            end
            if (fire) mul_o = {9'd0, ma} * {9'd0, mb};
            else if (force_fin) mul_o = 17'h1ABCD;
            mul_fin = fire | force_fin;
        end
    end

    // Protocol monitor and scoreboard consumer
    int          cyc = 0;
    int          last_done_cyc = -10;
    bit          outstanding = 0;
    logic [16:0] res_hold = '0;
    exp_t        got;

    initial begin
        forever begin
            @(posedge ck);
            #1;
            cyc++;
            if (rst) begin
                outstanding = 0;
                res_hold    = '0;
            end else begin
                if (ack0 || ack1) begin
                    chk("ack_excl", 64'(ack0 & ack1), 0);
                    chk("ack_spacing", 64'(outstanding || (cyc <= last_done_cyc + 1)), 0);
                    chk("ack_start", 64'(mul_start), 1);
                    chk("ack_mul_a", 64'(mul_a), 64'(ack0 ? a0 : a1));
                    chk("ack_mul_b", 64'(mul_b), 64'(ack0 ? b0 : b1));
                    outstanding = 1;
                end else if (mul_start) begin
                    chk("start_without_ack", 64'(mul_start), 0);
                end
                if (done0 || done1) begin
                    chk("done_excl", 64'(done0 & done1), 0);
                    chk("done_expected", 64'(sb.size() == 0), 0);
                    if (sb.size() != 0) begin
                        got = sb.pop_front();
                        chk("done_id", 64'(done1), 64'(got.id));
                        chk("done_res", 64'(res), 64'(got.res));
                        chk("done_err", 64'(err), 64'(got.err));
                    end
                    outstanding   = 0;
                    last_done_cyc = cyc;
                    res_hold      = res;
                end else begin
                    chk("res_hold", 64'(res), 64'(res_hold));
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge ck);
            n++;
        end
        chk("drain_bound", 64'(n >= 300), 0);
        if (n >= 300) sb.delete();
        repeat (2) @(negedge ck);
    endtask

    task automatic run_pair(input logic r0, input logic [7:0] x0, input logic [7:0] y0,
                            input logic r1, input logic [7:0] x1, input logic [7:0] y1,
                            input int lat, input logic first,
                            input logic [16:0] e0, input logic [16:0] e1, input logic ee);
        int n;
        lat_v = lat;
        if (r0 && r1) begin
            push(first, first ? e1 : e0, ee);
            push(~first, first ? e0 : e1, ee);
        end else if (r0) begin
            push(1'b0, e0, ee);
        end else begin
            push(1'b1, e1, ee);
        end
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        req0 = r0; req1 = r1;
        n = 0;
        while ((req0 || req1 || sb.size() != 0) && n < 300) begin
            @(negedge ck);
            n++;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        chk("run_bound", 64'(n >= 300), 0);
        if (n >= 300) begin
            sb.delete();
            req0 = 1'b0;
            req1 = 1'b0;
        end
        repeat (2) @(negedge ck);
    endtask

    task automatic hold_reqs(input logic r0, input logic r1, input int count);
        int n;
        int k;
        req0 = r0; req1 = r1;
        n = 0; k = 0;
        while (k < count && n < 300) begin
            @(negedge ck);
            n++;
            if (ack0 || ack1) k++;
        end
        chk("hold_bound", 64'(n >= 300), 0);
        req0 = 1'b0; req1 = 1'b0;
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //           r0  a0     b0     r1  a1     b1     lat first e0         e1
        vecs[0] = '{1'b1, 8'h03, 8'h05, 1'b1, 8'hFF, 8'hFF, 9, 1'b0, 17'h0000F, 17'h0FE01};
        vecs[1] = '{1'b1, 8'h0F, 8'h0F, 1'b0, 8'h00, 8'h00, 9, 1'b0, 17'h000E1, 17'h00000};
        vecs[2] = '{1'b1, 8'hAA, 8'h55, 1'b1, 8'h12, 8'h34, 3, 1'b1, 17'h03872, 17'h003A8};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF, 8'h01, 1, 1'b1, 17'h00000, 17'h000FF};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h80, 5, 1'b1, 17'h00000, 17'h04000};
        vecs[5] = '{1'b1, 8'hFF, 8'h00, 1'b1, 8'h7F, 8'h02, 2, 1'b0, 17'h00000, 17'h000FE};
        vecs[6] = '{1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 8'h00, 1, 1'b0, 17'h00001, 17'h00000};

        repeat (2) @(negedge ck);
        chk("rst_ack", 64'({ack0, ack1}), 0);
        chk("rst_done", 64'({done0, done1}), 0);
        chk("rst_res", 64'(res), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_mul_ab", 64'({mul_a, mul_b}), 0);
        chk("rst_start", 64'(mul_start), 0);
        rst = 1'b0;
        repeat (2) @(negedge ck);

        for (int i = 0; i < 7; i++) begin
            run_pair(vecs[i].r0, vecs[i].a0, vecs[i].b0, vecs[i].r1, vecs[i].a1, vecs[i].b1,
                     vecs[i].lat, vecs[i].first, vecs[i].e0, vecs[i].e1, 1'b0);
        end

        // Both held: requester 0 was served last, so grants go 1,0,1,0
        lat_v = 2;
        a0 = 8'h02; b0 = 8'h03; a1 = 8'h04; b1 = 8'h05;
        push(1'b1, 17'h14, 1'b0);
        push(1'b0, 17'h06, 1'b0);
        push(1'b1, 17'h14, 1'b0);
        push(1'b0, 17'h06, 1'b0);
        hold_reqs(1'b1, 1'b1, 4);

        // Only requester 1, held for three operations
        for (int i = 0; i < 3; i++) push(1'b1, 17'h14, 1'b0);
        hold_reqs(1'b0, 1'b1, 3);

        // Stale completion flag high during the start cycle must be ignored
        force_fin = 1;
        run_pair(1'b1, 8'h09, 8'h07, 1'b0, 8'h00, 8'h00, 4, 1'b0, 17'h0003F, 17'h0, 1'b0);

        // Reset in the middle of BUSY; the late mul_fin must not produce a done
        lat_v = 8;
        a0 = 8'h11; b0 = 8'h11; req0 = 1'b1;
        begin
            int n;
            n = 0;
            while (!ack0 && n < 50) begin
                @(negedge ck);
                n++;
            end
        end
        chk("rst_busy_ack", 64'(ack0), 1);
        req0 = 1'b0;
        repeat (2) @(negedge ck);
        rst = 1'b1;
        #1;
        chk("rst_busy_outs", 64'({ack0, ack1, done0, done1, res, err, mul_a, mul_b, mul_start}), 0);
        repeat (2) @(negedge ck);
        rst = 1'b0;
        repeat (12) @(negedge ck);
        chk("post_rst_res", 64'(res), 0);
        chk("post_rst_err", 64'(err), 0);
        run_pair(1'b1, 8'h03, 8'h03, 1'b1, 8'h02, 8'h02, 4, 1'b0, 17'h00009, 17'h00004, 1'b0);

`ifdef MUL_ARB_TIMEOUT_EN
        run_pair(1'b1, 8'h05, 8'h05, 1'b0, 8'h00, 8'h00, 0, 1'b0, 17'h00000, 17'h0, 1'b1);
        run_pair(1'b1, 8'h06, 8'h07, 1'b0, 8'h00, 8'h00, 3, 1'b0, 17'h0002A, 17'h0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
